muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/mdu_pkg.sv | 35 +++
 rtl/muldiv_core.sv | 76 +++++++
 rtl/muldiv_unit.sv | 91 +++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit:
// op codes, default width and latencies.
package mdu_pkg;

    localparam int WIDTH_DEF   = 32;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;
    localparam int CNT_W       = 5;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MFHI  = 4'd9,
        OP_MFLO  = 4'd10,
        OP_MTHI  = 4'd11,
        OP_MTLO  = 4'd12
    } op_e;

    function automatic logic is_mul(input logic [3:0] op);
        return op inside {OP_MULT, OP_MULTU, OP_MADD,
                          OP_MADDU, OP_MSUB, OP_MSUBU};
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return op inside {OP_DIV, OP_DIVU};
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational HI/LO result for multiply, accumulate
// and divide ops, from latched operands.
module muldiv_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int W2 = 2 * WIDTH;

    logic             sgn_mul;
    logic             sgn_div;
    logic             neg_a;
    logic             neg_b;
    logic [W2-1:0]    ext_a;
    logic [W2-1:0]    ext_b;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    acc;
    logic [W2-1:0]    res;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    always_comb begin
        sgn_mul = op inside {OP_MULT, OP_MADD, OP_MSUB};
        sgn_div = (op == OP_DIV);
        ext_a = sgn_mul ? {{WIDTH{a[WIDTH-1]}}, a}
                        : {{WIDTH{1'b0}}, a};
        ext_b = sgn_mul ? {{WIDTH{b[WIDTH-1]}}, b}
                        : {{WIDTH{1'b0}}, b};
        prod = ext_a * ext_b;
        acc  = {hi, lo};

        // magnitude divide; most-negative / -1 wraps to itself
        neg_a = sgn_div & a[WIDTH-1];
        neg_b = sgn_div & b[WIDTH-1];
        mag_a = neg_a ? -a : a;
        mag_b = neg_b ? -b : b;
        q_mag = '0;
        r_mag = '0;
        if (b != '0) begin
            q_mag = mag_a / mag_b;
            r_mag = mag_a % mag_b;
        end
        if (b == '0) begin
            quo = '1;
            rem = a;
        end else begin
            quo = (neg_a ^ neg_b) ? -q_mag : q_mag;
            rem = neg_a ? -r_mag : r_mag;
        end

        res = acc;
        unique case (1'b1)
            op inside {OP_MULT, OP_MULTU}: res = prod;
            op inside {OP_MADD, OP_MADDU}: res = acc + prod;
            op inside {OP_MSUB, OP_MSUBU}: res = acc - prod;
            op inside {OP_DIV, OP_DIVU}:   res = {rem, quo};
            default: ;
        endcase
        res_hi = res[W2-1:WIDTH];
        res_lo = res[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit with fixed-latency busy
// window, cancel and MFHI/MFLO/MTHI/MTLO support.
module muldiv_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    logic [CNT_W-1:0] cnt;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi),
        .lo     (lo),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign busy = (cnt != '0);

    always_comb begin
        out = '0;
        if (op == OP_MFHI) out = hi;
        else if (op == OP_MFLO) out = lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                cnt <= '0;
            end else if (busy) begin
                cnt <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
            end else if (start) begin
                unique case (1'b1)
                    is_mul(op): begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        cnt  <= CNT_W'(MUL_LAT);
                    end
                    is_div(op): begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                        cnt  <= CNT_W'(DIV_LAT);
                    end
                    op == OP_MTHI: hi <= a;
                    op == OP_MTLO: lo <= a;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops, cancel,
// busy-collision and reset-abort scenarios.
module tb_muldiv_unit;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] out;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;
    int n;

    muldiv_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!reset && done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 hi=%h lo=%h with nothing pending",
                         hi, lo);
            end else begin
                exp_v = sb_q.pop_front();
                if ({hi, lo} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got hi=%h lo=%h, expected hi=%h lo=%h",
                             hi, lo, exp_v[63:32], exp_v[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        tick();
        start = 1'b0;
        op = OP_NONE;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 64) begin
            cnt++;
            tick();
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] expv, input int lat);
        int c;
        sb_q.push_back(expv);
        issue(o, x, y);
        count_busy(c);
        check({name, "_busy"}, 64'(c), 64'(lat));
        tick();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = OP_NONE;
        a = '0;
        b = '0;
        cancel = 1'b0;
        tick();
        check("reset_state", {28'h0, busy, done, 2'b00, hi, lo}, 64'h0);
        reset = 1'b0;
        tick();

        run_op("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3,
               64'hFFFF_FFFF_FFFF_FFFA, 5);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 10);
        run_op("divu0", OP_DIVU, 32'd7, 32'd0,
               64'h0000_0007_FFFF_FFFF, 10);
        run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               64'h0000_0000_8000_0000, 10);
        run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               64'hFFFF_FFFE_0000_0001, 5);

        issue(OP_MTHI, 32'd1, 32'd0);
        check("mthi_nobusy", {63'h0, busy}, 64'h0);
        issue(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        check("mt_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
        run_op("maddu", OP_MADDU, 32'd1, 32'd1,
               64'h0000_0002_0000_0000, 5);
        run_op("msub", OP_MSUB, 32'd1, 32'd1,
               64'h0000_0001_FFFF_FFFF, 5);

        issue(OP_MTHI, 32'h55, 32'd0);
        issue(OP_MTLO, 32'h55, 32'd0);
        issue(OP_MULT, 32'd3, 32'd4);
        tick();
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", {63'h0, busy}, 64'h0);
        repeat (8) tick();
        check("cancel_hilo", {hi, lo}, 64'h0000_0055_0000_0055);

        start = 1'b1;
        op = OP_MTHI;
        a = 32'h99;
        cancel = 1'b1;
        tick();
        start = 1'b0;
        op = OP_NONE;
        cancel = 1'b0;
        check("cancel_mthi", {hi, lo}, 64'h0000_0055_0000_0055);

        issue(OP_MULT, 32'd3, 32'd4);
        repeat (4) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_last_busy", {63'h0, busy}, 64'h0);
        repeat (3) tick();
        check("cancel_last_hilo", {hi, lo}, 64'h0000_0055_0000_0055);

        issue(OP_MFHI, 32'h1234, 32'd0);
        issue(OP_NONE, 32'h1234, 32'd0);
        check("nop_state", {hi, lo}, 64'h0000_0055_0000_0055);

        sb_q.push_back(64'h0000_0002_0000_000E);
        issue(OP_DIV, 32'd100, 32'd7);
        start = 1'b1;
        op = OP_MULT;
        a = 32'd5;
        b = 32'd5;
        tick();
        start = 1'b0;
        op = OP_MFLO;
        #1;
        check("mflo_busy", {32'h0, out}, 64'h55);
        op = OP_MFHI;
        #1;
        check("mfhi_busy", {32'h0, out}, 64'h55);
        op = OP_NONE;
        count_busy(n);
        check("collide_busy", 64'(n + 1), 64'd10);
        repeat (8) tick();
        check("collide_idle", {63'h0, busy}, 64'h0);
        op = OP_MFLO;
        #1;
        check("mflo_after", {32'h0, out}, 64'h0E);
        op = OP_NONE;
        #1;
        check("out_none", {32'h0, out}, 64'h0);

        issue(OP_DIV, 32'd100, 32'd7);
        repeat (3) tick();
        #3;
        reset = 1'b1;
        #1;
        check("reset_mid", {31'h0, busy, hi, lo}, 64'h0);
        tick();
        reset = 1'b0;
        repeat (15) tick();
        check("reset_idle", {63'h0, busy}, 64'h0);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
